// File: rtl/montgomery_wrapper.sv
// montgomery_wrapper: iterative radix-2 Montgomery modular multiplier y = a*b mod m
// Ports: clk, rst (sync, active-high); enable_p start pulse sampling a, b, m, m_size, r_red;
//        y result held until the next done; done_irq_p one-cycle pulse when y updates.
// MONT_DOMAIN_CONV_EN: when defined, a second pass with r_red = R^2 mod m converts the result
//        out of the Montgomery domain; when undefined, y = a*b*R^-1 mod m and r_red is ignored.
module montgomery_wrapper #(
  parameter int NBITS = 4096,
  parameter int PBITS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable_p,
  input  logic [NBITS-1:0]           a,
  input  logic [NBITS-1:0]           b,
  input  logic [NBITS-1:0]           m,
  input  logic [$clog2(NBITS)+2:0]   m_size,
  input  logic [NBITS-1:0]           r_red,
  output logic [NBITS-1:0]           y,
  output logic                       done_irq_p
);
  localparam int W = $clog2(NBITS) + 3;
  localparam logic [W-1:0] PW = W'(PBITS);
  typedef enum logic [2:0] {IDLE, ITER1, FIN1, ITER2, FIN2} state_t;
  state_t state_q, state_d;
  logic [NBITS-1:0] a_q, b_q, m_q, y_q, red;
  logic [NBITS+1:0] s_q, s_n;
  logic [W-1:0] cnt_q, msz_q;
  logic done_q, cap, iter, mid, fin, last;
`ifdef MONT_DOMAIN_CONV_EN
  logic [NBITS-1:0] rr_q;
`else
  logic unused_rr;
  assign unused_rr = ^r_red;
`endif
  // >= rather than == so a malformed m_size still terminates at ceil(m_size/PBITS) cycles
  assign last = cnt_q + PW >= msz_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (enable_p) state_d = ITER1;
      ITER1: if (last) state_d = FIN1;
`ifdef MONT_DOMAIN_CONV_EN
      FIN1:  state_d = ITER2;
      ITER2: if (last) state_d = FIN2;
      FIN2:  state_d = IDLE;
`else
      FIN1:  state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cap  = state_q == IDLE && enable_p;
    iter = state_q == ITER1 || state_q == ITER2;
`ifdef MONT_DOMAIN_CONV_EN
    mid  = state_q == FIN1;
    fin  = state_q == FIN2;
`else
    mid  = 1'b0;
    fin  = state_q == FIN1;
`endif
  end
  // PBITS unrolled radix-2 steps; S stays below 4m so NBITS+2 bits never overflow
  always_comb begin
    s_n = s_q;
    for (int i = 0; i < PBITS; i++) begin
      s_n = s_n + (a_q[i] ? {2'b0, b_q} : '0);
      s_n = s_n + (s_n[0] ? {2'b0, m_q} : '0);
      s_n = s_n >> 1;
    end
  end
  assign red = (s_q >= {2'b0, m_q}) ? NBITS'(s_q - {2'b0, m_q}) : s_q[NBITS-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      m_q <= '0;
      s_q <= '0;
      cnt_q <= '0;
      msz_q <= '0;
      y_q <= '0;
      done_q <= 1'b0;
`ifdef MONT_DOMAIN_CONV_EN
      rr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      done_q <= fin;
      if (cap) begin
        a_q <= a;
        b_q <= b;
        m_q <= m;
        msz_q <= m_size;
        s_q <= '0;
        cnt_q <= '0;
`ifdef MONT_DOMAIN_CONV_EN
        rr_q <= r_red;
`endif
      end
      // A is consumed LSB first by shifting, so the step logic always reads a_q[PBITS-1:0]
      if (iter) begin
        s_q <= s_n;
        a_q <= a_q >> PBITS;
        cnt_q <= cnt_q + PW;
      end
`ifdef MONT_DOMAIN_CONV_EN
      if (mid) begin
        a_q <= red;
        b_q <= rr_q;
        s_q <= '0;
        cnt_q <= '0;
      end
`endif
      if (fin) y_q <= red;
    end
  end
  assign y = y_q;
  assign done_irq_p = done_q;
endmodule

// File: tb/tb_montgomery_wrapper.sv
// tb_montgomery_wrapper: table-driven and scoreboard checks of montgomery_wrapper
module tb_montgomery_wrapper;
`ifdef MONT_DOMAIN_CONV_EN
  localparam int LAT = 10, LAT2 = 1026;
  localparam logic [7:0] Y0 = 3, Y75 = 9, Y1212 = 1;
`else
  localparam int LAT = 5, LAT2 = 513;
  localparam logic [7:0] Y0 = 3, Y75 = 1, Y1212 = 3;
`endif
  logic clk = 0, rst = 1, en = 0, done, en2 = 0, done2;
  logic [7:0] a = 0, b = 0, m = 1, rr = 0, y;
  logic [5:0] msz = 6'd8;
  logic [4095:0] a2, b2, m2, rr2, y2;
  logic [14:0] msz2 = 15'd4096;
  always #5 clk = ~clk;
  montgomery_wrapper #(.NBITS(8), .PBITS(2)) dut (
    .clk(clk), .rst(rst), .enable_p(en), .a(a), .b(b), .m(m), .m_size(msz),
    .r_red(rr), .y(y), .done_irq_p(done));
  montgomery_wrapper #(.NBITS(4096), .PBITS(8)) dut2 (
    .clk(clk), .rst(rst), .enable_p(en2), .a(a2), .b(b2), .m(m2), .m_size(msz2),
    .r_red(rr2), .y(y2), .done_irq_p(done2));
  typedef struct {logic [7:0] a, b, m, rr, y;} vec_t;
  typedef struct {logic [7:0] y; time t;} exp_t;
  vec_t tv[8];
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  logic [7:0] prev_y = 0;
  logic prev_done = 0;
  function automatic logic [7:0] model(int ma, int mb, int mm);
`ifdef MONT_DOMAIN_CONV_EN
    return 8'((ma * mb) % mm);
`else
    int r = 0;
    for (int x = 0; x < mm; x++) if ((256 * x) % mm == 1) r = x;
    return 8'(((ma * mb) % mm) * r % mm);
`endif
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (done) begin
        chk("done_width", int'(prev_done), 0);
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("y", int'(y), int'(e.y));
          chk("latency", int'(($time - 1 - e.t) / 10), LAT);
        end
      end else if (y != prev_y) chk("y_stable", int'(y), int'(prev_y));
    end
    prev_y = y;
    prev_done = done;
  end
  task automatic issue(input logic [7:0] ia, ib, im, irr, ey);
    a = ia;
    b = ib;
    m = im;
    rr = irr;
    en = 1;
    @(posedge clk);
    q.push_back('{ey, $time});
    #1 en = 0;
    a = 8'($urandom);
    b = 8'($urandom);
    m = 8'($urandom);
    rr = 8'($urandom);
    @(negedge clk);
  endtask
  task automatic wait_done(input int lim);
    int n = 0;
    while (!done && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("timeout", 0, 1);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_y", int'(y), 0);
    chk("rst_done", int'(done), 0);
    rst = 0;
    tv[0] = '{254, 252, 255, 1, Y0};
    tv[1] = '{7, 5, 13, 3, Y75};
    tv[2] = '{12, 12, 13, 3, Y1212};
    tv[3] = '{0, 9, 13, 3, 0};
    for (int i = 4; i < 8; i++) begin
      int vm, va, vb;
      vm = 2 * int'($urandom_range(1, 127)) + 1;
      va = int'($urandom_range(0, vm - 1));
      vb = int'($urandom_range(0, vm - 1));
      tv[i] = '{8'(va), 8'(vb), 8'(vm), 8'(65536 % vm), model(va, vb, vm)};
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      issue(tv[i].a, tv[i].b, tv[i].m, tv[i].rr, tv[i].y);
      wait_done(40);
    end
    issue(7, 5, 13, 3, Y75);
    wait_done(40);
    issue(7, 5, 13, 3, Y75);
    repeat (2) @(negedge clk);
    a = 1;
    b = 1;
    m = 13;
    en = 1;
    @(negedge clk);
    en = 0;
    wait_done(40);
    issue(12, 12, 13, 3, Y1212);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    q.delete();
    repeat (15) @(negedge clk);
    chk("abort_y", int'(y), 0);
    chk("abort_done", int'(done), 0);
    issue(7, 5, 13, 3, Y75);
    wait_done(40);
    m2 = '1;
    a2 = m2 - 1;
    b2 = m2 - 3;
    rr2 = 1;
    @(negedge clk);
    en2 = 1;
    @(posedge clk);
    #1 en2 = 0;
    n = 0;
    while (!done2 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("big_latency", n, LAT2);
    checks++;
    if (y2 !== 4096'd3) begin
      errors++;
      $display("FAIL big_y got low word %0d expected 3", y2[31:0]);
    end
    repeat (3) @(negedge clk);
    if (q.size() != 0) chk("pending", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
